// File: rtl/axi_ram_slave_pkg.sv
// Shared types and constants for the AXI4 RAM slave front-end.
package axi_ram_slave_pkg;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 64;
  localparam int AXI_LEN_W = 8;
  localparam int STRB_W    = DATA_W / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_WRESP = 2'd3
  } state_t;

  // Expand each byte strobe into a full byte of the RAM bit mask.
  function automatic logic [DATA_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

  // The RAM port is 8 bytes wide, so the low address bits are dropped.
  function automatic logic [ADDR_W-1:0] align8(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/axi_ram_slave.sv
// AXI4 slave that serialises INCR bursts into single-beat accesses on one
// shared RAM port. Reads and writes are arbitrated round-robin on ties.
module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter int          ID_W = 4,
  parameter logic [63:0] BASE = 64'h0000_0000_8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  // write address
  input  logic [ID_W-1:0]      awid,
  input  logic [ADDR_W-1:0]    awaddr,
  input  logic [AXI_LEN_W-1:0] awlen,
  input  logic [1:0]           awburst,
  input  logic                 awvalid,
  output logic                 awready,
  // write data
  input  logic [DATA_W-1:0]    wdata,
  input  logic [STRB_W-1:0]    wstrb,
  input  logic                 wlast,
  input  logic                 wvalid,
  output logic                 wready,
  // write response
  output logic [ID_W-1:0]      bid,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  // read address
  input  logic [ID_W-1:0]      arid,
  input  logic [ADDR_W-1:0]    araddr,
  input  logic [AXI_LEN_W-1:0] arlen,
  input  logic [1:0]           arburst,
  input  logic                 arvalid,
  output logic                 arready,
  // read data
  output logic [ID_W-1:0]      rid,
  output logic [DATA_W-1:0]    rdata,
  output logic [1:0]           rresp,
  output logic                 rlast,
  output logic                 rvalid,
  input  logic                 rready,
  // RAM port
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_W-1:0]    data_addr,
  output logic [DATA_W-1:0]    write_mask,
  output logic [DATA_W-1:0]    write_data,
  input  logic [DATA_W-1:0]    read_data
);

  state_t                state_q, state_nxt;
  logic                  last_was_wr_q, last_was_wr_nxt;
  logic [ID_W-1:0]       id_q, id_nxt;
  logic [ADDR_W-1:0]     addr_q, addr_nxt;
  logic [AXI_LEN_W-1:0]  len_q, len_nxt;
  logic [AXI_LEN_W-1:0]  beat_q, beat_nxt;
  logic                  rvalid_q, rvalid_nxt;
  logic                  rlast_q, rlast_nxt;
  logic [DATA_W-1:0]     rdata_q, rdata_nxt;
  logic                  bvalid_q, bvalid_nxt;
  logic [1:0]            bresp_q, bresp_nxt;
  logic                  grant_rd;
  logic                  at_last_beat;

  // Burst type is ignored (everything runs as INCR) and BASE is only a label;
  // the RAM subtracts it itself.
  logic unused_inputs;
  assign unused_inputs = ^{awburst, arburst, BASE, awaddr[2:0], araddr[2:0]};

  // Reads win a tie unless the previous transaction was also a read.
  assign grant_rd     = arvalid && (!awvalid || last_was_wr_q);
  assign at_last_beat = (beat_q == len_q);

  assign rid    = id_q;
  assign bid    = id_q;
  assign rvalid = rvalid_q;
  assign rlast  = rlast_q;
  assign rdata  = rdata_q;
  assign rresp  = AXI_RESP_OKAY;
  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;

  // Next-state, burst bookkeeping and RAM strobes for the single FSM.
  always_comb begin
    state_nxt       = state_q;
    last_was_wr_nxt = last_was_wr_q;
    id_nxt          = id_q;
    addr_nxt        = addr_q;
    len_nxt         = len_q;
    beat_nxt        = beat_q;
    rvalid_nxt      = rvalid_q;
    rlast_nxt       = rlast_q;
    rdata_nxt       = rdata_q;
    bvalid_nxt      = bvalid_q;
    bresp_nxt       = bresp_q;
    arready         = 1'b0;
    awready         = 1'b0;
    wready          = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    data_addr       = '0;
    write_mask      = '0;
    write_data      = '0;

    unique case (state_q)
      ST_IDLE: begin
        arready = arvalid && grant_rd;
        awready = awvalid && !grant_rd;
        if (arready) begin
          id_nxt          = arid;
          addr_nxt        = align8(araddr);
          len_nxt         = arlen;
          beat_nxt        = '0;
          last_was_wr_nxt = 1'b0;
          state_nxt       = ST_RD;
        end else if (awready) begin
          id_nxt          = awid;
          addr_nxt        = align8(awaddr);
          len_nxt         = awlen;
          beat_nxt        = '0;
          last_was_wr_nxt = 1'b1;
          state_nxt       = ST_WR;
        end
      end

      ST_RD: begin
        if (rvalid_q && rready && rlast_q) begin
          rvalid_nxt = 1'b0;
          rlast_nxt  = 1'b0;
          state_nxt  = ST_IDLE;
        end else if (!rvalid_q || (rready && !rlast_q)) begin
          // RAM read is combinational: capture the word in the access cycle.
          mem_read   = 1'b1;
          data_addr  = addr_q;
          rdata_nxt  = read_data;
          rvalid_nxt = 1'b1;
          rlast_nxt  = at_last_beat;
          addr_nxt   = addr_q + 64'd8;
          beat_nxt   = beat_q + 8'd1;
        end
      end

      ST_WR: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_write  = 1'b1;
          data_addr  = addr_q;
          write_mask = strb_to_mask(wstrb);
          write_data = wdata;
          addr_nxt   = addr_q + 64'd8;
          beat_nxt   = beat_q + 8'd1;
          // A wlast/len disagreement ends the burst early with an error;
          // any beats the master still has are left unaccepted.
          if (wlast || at_last_beat) begin
            bvalid_nxt = 1'b1;
            bresp_nxt  = (wlast && at_last_beat) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            state_nxt  = ST_WRESP;
          end
        end
      end

      ST_WRESP: begin
        if (bready) begin
          bvalid_nxt = 1'b0;
          bresp_nxt  = AXI_RESP_OKAY;
          state_nxt  = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and burst registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_was_wr_q <= 1'b1;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      rdata_q       <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= AXI_RESP_OKAY;
    end else begin
      state_q       <= state_nxt;
      last_was_wr_q <= last_was_wr_nxt;
      id_q          <= id_nxt;
      addr_q        <= addr_nxt;
      len_q         <= len_nxt;
      beat_q        <= beat_nxt;
      rvalid_q      <= rvalid_nxt;
      rlast_q       <= rlast_nxt;
      rdata_q       <= rdata_nxt;
      bvalid_q      <= bvalid_nxt;
      bresp_q       <= bresp_nxt;
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: reads, writes, arbitration, error
// responses and mid-burst reset, against a combinational RAM model.
module tb_axi_ram_slave;

  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [ID_W-1:0] awid, arid, bid, rid;
  logic [63:0]     awaddr, araddr, wdata, rdata;
  logic [7:0]      awlen, arlen, wstrb;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic            mem_read, mem_write;
  logic [63:0]     data_addr, write_mask, write_data, read_data;

  int n_chk  = 0;
  int n_pass = 0;

  axi_ram_slave #(.ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .mem_read(mem_read), .mem_write(mem_write), .data_addr(data_addr),
    .write_mask(write_mask), .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // RAM contents: a fixed, address-dependent pattern.
  function automatic logic [63:0] ram_word(input logic [63:0] a);
    return {a[31:0], ~a[31:0]} ^ 64'h0123_4567_89ab_cdef;
  endfunction

  assign read_data = ram_word(data_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic quiet_inputs();
    awid = '0; awaddr = '0; awlen = '0; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic pat [6]       = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int   exp_beat [6]  = '{0, 1, 1, 2, 3, 3};

  initial begin
    quiet_inputs();
    do_reset();

    // ---- reset state
    settle();
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready",  64'(wready),  64'd0);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_bvalid",  64'(bvalid),  64'd0);
    chk("rst_memrw",   64'({mem_read, mem_write}), 64'd0);
    chk("rst_addr",    data_addr, 64'd0);
    chk("rst_rdata",   rdata, 64'd0);

    // ---- single read, arlen=0
    arvalid = 1'b1; araddr = 64'h8000_0010; arlen = 8'd0; arid = 4'd3;
    settle();
    chk("rd1_arready", 64'(arready), 64'd1);
    step();
    arvalid = 1'b0; rready = 1'b1;
    settle();
    chk("rd1_memread", 64'(mem_read), 64'd1);
    chk("rd1_addr",    data_addr, 64'h8000_0010);
    chk("rd1_rvalid0", 64'(rvalid), 64'd0);
    step();
    settle();
    chk("rd1_rvalid",  64'(rvalid), 64'd1);
    chk("rd1_rlast",   64'(rlast), 64'd1);
    chk("rd1_rdata",   rdata, ram_word(64'h8000_0010));
    chk("rd1_rid",     64'(rid), 64'd3);
    chk("rd1_rresp",   64'(rresp), 64'd0);
    chk("rd1_noissue", 64'(mem_read), 64'd0);
    step();
    rready = 1'b0;
    settle();
    chk("rd1_done", 64'(rvalid), 64'd0);

    // ---- read burst arlen=3 on an unaligned address, rready 1,0,1,1,0,1
    arvalid = 1'b1; araddr = 64'h8000_0203; arlen = 8'd3; arid = 4'd5;
    settle();
    chk("rdb_arready", 64'(arready), 64'd1);
    step();
    arvalid = 1'b0;
    settle();
    chk("rdb_memread0", 64'(mem_read), 64'd1);
    chk("rdb_addr0",    data_addr, 64'h8000_0200);
    step();
    for (int i = 0; i < 6; i++) begin
      rready = pat[i];
      settle();
      chk($sformatf("rdb_rvalid%0d", i), 64'(rvalid), 64'd1);
      chk($sformatf("rdb_rdata%0d", i), rdata,
          ram_word(64'h8000_0200 + 64'(8 * exp_beat[i])));
      chk($sformatf("rdb_rlast%0d", i), 64'(rlast), 64'(exp_beat[i] == 3));
      chk($sformatf("rdb_memread%0d", i), 64'(mem_read),
          64'(pat[i] && exp_beat[i] != 3));
      if (pat[i] && exp_beat[i] != 3)
        chk($sformatf("rdb_addr%0d", i), data_addr,
            64'h8000_0200 + 64'(8 * (exp_beat[i] + 1)));
      step();
    end
    rready = 1'b0;
    settle();
    chk("rdb_done", 64'(rvalid), 64'd0);

    // ---- write burst awlen=1, strobes 0x0F then 0xF0
    awvalid = 1'b1; awaddr = 64'h8000_0100; awlen = 8'd1; awid = 4'd9;
    settle();
    chk("wr_awready", 64'(awready), 64'd1);
    step();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 64'h1111_2222_3333_4444; wstrb = 8'h0F; wlast = 1'b0;
    settle();
    chk("wr_wready0", 64'(wready), 64'd1);
    chk("wr_memw0",   64'({mem_write, mem_read}), 64'b10);
    chk("wr_addr0",   data_addr, 64'h8000_0100);
    chk("wr_mask0",   write_mask, 64'h0000_0000_FFFF_FFFF);
    chk("wr_data0",   write_data, 64'h1111_2222_3333_4444);
    step();
    wdata = 64'hAAAA_BBBB_CCCC_DDDD; wstrb = 8'hF0; wlast = 1'b1;
    settle();
    chk("wr_addr1",   data_addr, 64'h8000_0108);
    chk("wr_mask1",   write_mask, 64'hFFFF_FFFF_0000_0000);
    chk("wr_data1",   write_data, 64'hAAAA_BBBB_CCCC_DDDD);
    step();
    wvalid = 1'b0; wlast = 1'b0;
    settle();
    chk("wr_bvalid",  64'(bvalid), 64'd1);
    chk("wr_bresp",   64'(bresp), 64'd0);
    chk("wr_bid",     64'(bid), 64'd9);
    chk("wr_wready_off", 64'(wready), 64'd0);
    step();
    bready = 1'b1;
    settle();
    chk("wr_bhold", 64'(bvalid), 64'd1);
    step();
    bready = 1'b0;
    settle();
    chk("wr_bdone", 64'(bvalid), 64'd0);

    // ---- arbitration: two ties after reset
    do_reset();
    arvalid = 1'b1; araddr = 64'h8000_0600; arlen = 8'd0; arid = 4'd1;
    awvalid = 1'b1; awaddr = 64'h8000_0700; awlen = 8'd0; awid = 4'd2;
    settle();
    chk("tie1_arready", 64'(arready), 64'd1);
    chk("tie1_awready", 64'(awready), 64'd0);
    step();
    arvalid = 1'b0; rready = 1'b1;
    settle();
    chk("tie1_awblock", 64'(awready), 64'd0);
    step();
    settle();
    chk("tie1_rid", 64'(rid), 64'd1);
    step();
    rready = 1'b0;
    arvalid = 1'b1; araddr = 64'h8000_0800; arid = 4'd4;
    settle();
    chk("tie2_awready", 64'(awready), 64'd1);
    chk("tie2_arready", 64'(arready), 64'd0);
    step();
    awvalid = 1'b0;
    wvalid = 1'b1; wstrb = 8'hFF; wdata = 64'h5; wlast = 1'b1;
    settle();
    chk("tie2_memw",  64'(mem_write), 64'd1);
    chk("tie2_waddr", data_addr, 64'h8000_0700);
    chk("tie2_arblk", 64'(arready), 64'd0);
    step();
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    settle();
    chk("tie2_bid", 64'(bid), 64'd2);
    step();
    bready = 1'b0;
    settle();
    chk("tie2_ar_after", 64'(arready), 64'd1);
    step();
    arvalid = 1'b0; rready = 1'b1;
    settle();
    chk("tie2_rdaddr", data_addr, 64'h8000_0800);
    step();
    step();
    rready = 1'b0;

    // ---- early wlast: awlen=2, wlast on 2nd beat
    awvalid = 1'b1; awaddr = 64'h8000_0300; awlen = 8'd2; awid = 4'd6;
    settle();
    chk("ew_awready", 64'(awready), 64'd1);
    step();
    awvalid = 1'b0;
    wvalid = 1'b1; wstrb = 8'hFF; wdata = 64'h10; wlast = 1'b0;
    settle();
    chk("ew_memw0", 64'(mem_write), 64'd1);
    step();
    wdata = 64'h11; wlast = 1'b1;
    settle();
    chk("ew_memw1", 64'(mem_write), 64'd1);
    chk("ew_addr1", data_addr, 64'h8000_0308);
    step();
    wdata = 64'h12; wlast = 1'b1;
    settle();
    chk("ew_nowrite", 64'(mem_write), 64'd0);
    chk("ew_wready",  64'(wready), 64'd0);
    chk("ew_bresp",   64'(bresp), 64'h2);
    chk("ew_bvalid",  64'(bvalid), 64'd1);
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    step();
    bready = 1'b0;

    // ---- missing wlast at beat==len: awlen=0, wlast low
    awvalid = 1'b1; awaddr = 64'h8000_0380; awlen = 8'd0; awid = 4'd7;
    step();
    awvalid = 1'b0;
    wvalid = 1'b1; wstrb = 8'h01; wdata = 64'h20; wlast = 1'b0;
    settle();
    chk("nl_mask", write_mask, 64'h0000_0000_0000_00FF);
    step();
    wvalid = 1'b0;
    settle();
    chk("nl_bresp", 64'(bresp), 64'h2);
    bready = 1'b1;
    step();
    bready = 1'b0;

    // ---- reset during beat 2 of an 8-beat read
    arvalid = 1'b1; araddr = 64'h8000_0400; arlen = 8'd7; arid = 4'd8;
    step();
    arvalid = 1'b0; rready = 1'b1;
    step();
    step();
    settle();
    chk("mr_beat2_addr", data_addr, 64'h8000_0410);
    rst = 1'b1;
    step();
    rst = 1'b0; rready = 1'b0;
    settle();
    chk("mr_rvalid", 64'(rvalid), 64'd0);
    chk("mr_rlast",  64'(rlast), 64'd0);
    chk("mr_rdata",  rdata, 64'd0);
    chk("mr_rid",    64'(rid), 64'd0);
    chk("mr_memrd",  64'(mem_read), 64'd0);
    chk("mr_addr",   data_addr, 64'd0);
    arvalid = 1'b1; araddr = 64'h8000_0500; arlen = 8'd0; arid = 4'd10;
    settle();
    chk("mr_arready", 64'(arready), 64'd1);
    step();
    arvalid = 1'b0; rready = 1'b1;
    settle();
    chk("mr_newaddr", data_addr, 64'h8000_0500);
    step();
    settle();
    chk("mr_newdata", rdata, ram_word(64'h8000_0500));
    chk("mr_newlast", 64'(rlast), 64'd1);
    chk("mr_newrid",  64'(rid), 64'd10);
    step();
    rready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_ram_slave.md
# axi_ram_slave

AXI4 slave front-end for the 64-bit simulation RAM data port. It accepts AXI4 INCR read and write bursts from the CPU's AXI master or crossbar. Each burst is serialised into single-beat RAM accesses on one shared port: `mem_read`/`mem_write`/`data_addr`/`write_mask`/`write_data`, with read data returned on `read_data`. The RAM read path is combinational, so data driven back in the same cycle as `mem_read` is valid.

## Interface
Parameters:
- `ID_W`, default 4: AXI ID width.
- `BASE`, default 64'h0000_0000_8000_0000: informational only; addresses are passed through unchanged and the RAM subtracts the base.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `awid/awaddr/awlen/awburst/awvalid`  in  ID_W/64/8/2/1: write address channel. `awsize` is not present; the size is fixed at 8 bytes.
- `awready`  out  1: write address ready.
- `wdata/wstrb/wlast/wvalid`  in  64/8/1/1: write data channel.
- `wready`  out  1: write data ready.
- `bid/bresp/bvalid`  out  ID_W/2/1: write response channel.
- `bready`  in  1: write response ready.
- `arid/araddr/arlen/arburst/arvalid`  in  ID_W/64/8/2/1: read address channel.
- `arready`  out  1: read address ready.
- `rid/rdata/rresp/rlast/rvalid`  out  ID_W/64/2/1/1: read data channel.
- `rready`  in  1: read data ready.
- `mem_read, mem_write`  out  1: RAM strobes.
- `data_addr`  out  64: RAM address, always 8-byte aligned (bits [2:0] forced to 0).
- `write_mask`  out  64: bit mask, with byte i equal to `{8{wstrb[i]}}`.
- `write_data`  out  64: RAM write data.
- `read_data`  in  64: combinational RAM read data.

## Operation
- FSM states: IDLE, RD, WR, WRESP.
- IDLE:
  - `arready = arvalid && grant_rd`.
  - `awready = awvalid && !grant_rd`.
  - `grant_rd` is 1 if only `arvalid` is asserted. When both `arvalid` and `awvalid` are asserted, it is the opposite of the last-served direction. The `last_was_wr` flag resets to 1, so reads win the first tie.
  - On handshake, latch the ID, address (aligned), and `len`; clear `beat`. An AR handshake moves to RD; an AW handshake moves to WR.
- RD:
  - An issue condition is `!rvalid || (rready && !rlast)`.
  - On issue: `mem_read=1`, `data_addr=addr`, capture `read_data` into `rdata`, `rvalid<=1`, `rlast<=(beat==len)`, `addr+=8`, `beat++`.
  - When `rvalid && rready && rlast`: clear `rvalid`, go to IDLE.
  - `rresp` is always OKAY (2'b00).
- WR:
  - `wready=1`.
  - On `wvalid`: `mem_write=1`, drive `data_addr`, `write_mask`, `write_data` that same cycle; `addr+=8`, `beat++`.
  - If `wlast` arrives at `beat==len`, go to WRESP with OKAY.
  - If `wlast` arrives early, or `beat==len` without `wlast`, go to WRESP with SLVERR (2'b10), latched. Remaining beats are not absorbed.
- WRESP: `bvalid=1` until `bready`, then go to IDLE.
- Burst types: FIXED and WRAP are treated as INCR. 4 KB boundaries are not checked. Addresses wrap modulo 2^64.
- `mem_read` and `mem_write` are never asserted in the same cycle.
- Reset: all outputs are 0; state is IDLE; `last_was_wr=1`. Reset mid-burst abandons the burst without a response.

## Timing
- Read: AR handshake at cycle T. First `rvalid` is at T+2 (RAM accessed in T+1). With `rready` held high, throughput is 1 beat per cycle, so `rlast` arrives at T+2+len.
- Write: AW handshake at T. `wready` is high from T+1. Each accepted beat writes the RAM in the same cycle. `bvalid` asserts the cycle after the last beat.
- A new AR or AW is accepted no earlier than the cycle after returning to IDLE.
- `arready` and `awready` are combinational from state and valid.

## Structure
- Add to the shared `defines.v`:
  - `AXI_RESP_OKAY`, `AXI_RESP_SLVERR`.
  - `AXI_BURST_INCR`.
  - `AXI_LEN_BUS` [7:0].
  - Reuse `DATA_BUS` and `DATA_ADDR_BUS` for the 64-bit buses.
- No sub-module: a single FSM with `addr`/`beat` registers.

## Test plan
- Single read, `araddr=0x8000_0010`, `arlen=0` → `mem_read` with `data_addr=0x8000_0010` at T+1; `rvalid`/`rlast` at T+2; `rdata` equals the RAM word.
- Read burst, `arlen=3`, with `rready` toggling 1,0,1,1,0,1 → 4 beats at addresses +0/+8/+16/+24; data held while stalled; `rlast` only on the 4th beat.
- Write burst, `awaddr=0x8000_0100`, `awlen=1`, `wstrb=0x0F` then `0xF0` → `write_mask` of `0x0000_0000_FFFF_FFFF` then `0xFFFF_FFFF_0000_0000`; `bresp=OKAY`; `bid` matches `awid`.
- `arvalid` and `awvalid` asserted together twice after reset → read served first, then write. On the second tie, write is served first.
- Write with `awlen=2` and `wlast` on the 2nd beat → 2 RAM writes only; `bresp=2'b10`.
- Assert `rst` during beat 2 of an 8-beat read → next cycle all outputs are 0, state is IDLE, and a fresh AR is accepted normally.
